// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue
//   Sequential instruction fetcher feeding a small in-order instruction queue.
//   Requests are issued word by word from fetch_pc, limited by a credit rule so
//   that every outstanding response is guaranteed a free queue slot. A redirect
//   flushes the queue and reloads both address pointers; responses to requests
//   issued before the redirect are counted as stale and dropped while the block
//   sits in DRAIN.
//
// Ports
//   clk, reset                       clock, synchronous active-high reset
//   redirect_valid, redirect_addr    branch/jump target (bits [1:0] ignored)
//   imem_req_valid/_addr/_ready      instruction-memory read request channel
//   imem_rsp_valid, imem_rsp_data    in-order read responses, no backpressure
//   instr_valid/_data/_pc/_ready     queue head towards decode
module instr_fetch_queue #(
  parameter int AddrSize = 32,
  parameter int DataSize = 32,
  parameter int Depth    = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                redirect_valid,
  input  logic [AddrSize-1:0] redirect_addr,
  output logic                imem_req_valid,
  output logic [AddrSize-1:0] imem_req_addr,
  input  logic                imem_req_ready,
  input  logic                imem_rsp_valid,
  input  logic [DataSize-1:0] imem_rsp_data,
  output logic                instr_valid,
  output logic [DataSize-1:0] instr_data,
  output logic [AddrSize-1:0] instr_pc,
  input  logic                instr_ready
);

  localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int CntW = PtrW + 1;
  localparam int SumW = CntW + 1;
  localparam logic [SumW-1:0] DepthSum = SumW'(Depth);
  localparam logic [AddrSize-1:0] Step = AddrSize'(4);

  typedef enum logic {FETCH, DRAIN} state_e;

  state_e              state_q;
  logic [AddrSize-1:0] fetch_pc_q;
  logic [AddrSize-1:0] rsp_pc_q;
  logic [PtrW-1:0]     wr_ptr_q;
  logic [PtrW-1:0]     rd_ptr_q;
  logic [CntW-1:0]     count_q;
  logic [CntW-1:0]     outst_q;
  logic [CntW-1:0]     stale_q;

  logic [AddrSize-1:0] pc_mem   [Depth];
  logic [DataSize-1:0] data_mem [Depth];

  logic [SumW-1:0]     credit_used;
  logic                req_fire;
  logic                rsp_stale;
  logic                enq;
  logic                deq;
  logic [CntW-1:0]     stale_redir;
  logic [AddrSize-1:0] redir_aligned;

  // Slots already claimed: entries in the queue plus responses still in flight.
  assign credit_used    = {1'b0, count_q} + {1'b0, outst_q};

  assign imem_req_valid = !reset && (state_q == FETCH) && !redirect_valid &&
                          (credit_used < DepthSum);
  assign imem_req_addr  = fetch_pc_q;

  assign instr_valid    = !reset && (count_q != '0);
  assign instr_data     = data_mem[rd_ptr_q];
  assign instr_pc       = pc_mem[rd_ptr_q];

  assign req_fire       = imem_req_valid && imem_req_ready;
  assign rsp_stale      = imem_rsp_valid && (stale_q != '0);
  // A response coinciding with a redirect belongs to the old stream and is dropped.
  assign enq            = imem_rsp_valid && (stale_q == '0) && !redirect_valid;
  assign deq            = instr_valid && instr_ready;

  // Everything accepted but not yet answered becomes stale; a response arriving
  // in the redirect cycle itself has already been answered.
  assign stale_redir    = stale_q + outst_q - CntW'(imem_rsp_valid);
  assign redir_aligned  = {redirect_addr[AddrSize-1:2], 2'b00};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= FETCH;
      fetch_pc_q <= '0;
      rsp_pc_q   <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      outst_q    <= '0;
      stale_q    <= '0;
    end else if (redirect_valid) begin
      fetch_pc_q <= redir_aligned;
      rsp_pc_q   <= redir_aligned;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      outst_q    <= '0;
      stale_q    <= stale_redir;
      state_q    <= (stale_redir != '0) ? DRAIN : FETCH;
    end else begin
      if (req_fire) begin
        fetch_pc_q <= fetch_pc_q + Step;
      end
      if (enq) begin
        rsp_pc_q <= rsp_pc_q + Step;
        wr_ptr_q <= wr_ptr_q + PtrW'(1);
      end
      if (deq) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      count_q <= count_q + CntW'(enq) - CntW'(deq);
      outst_q <= outst_q + CntW'(req_fire) - CntW'(enq);
      if (rsp_stale) begin
        stale_q <= stale_q - CntW'(1);
        // Leave DRAIN on the edge that drops the last stale word.
        if (stale_q == CntW'(1)) begin
          state_q <= FETCH;
        end
      end
    end
  end

  // Queue storage carries no reset; validity is tracked by count_q alone.
  always_ff @(posedge clk) begin
    if (enq) begin
      pc_mem[wr_ptr_q]   <= rsp_pc_q;
      data_mem[wr_ptr_q] <= imem_rsp_data;
    end
  end

endmodule

// File: doc/instr_fetch_queue.md
INSTR_FETCH_QUEUE -- requirements
Module: instr_fetch_queue

Interface
REQ-001 The block SHALL have parameter AddrSize, default 32: fetch address width in bits.
REQ-002 The block SHALL have parameter DataSize, default 32: instruction width in bits.
REQ-003 The block SHALL have parameter Depth, default 4: instruction queue entries, a power of two and at least 2.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port redirect_valid, input, 1 bit: a branch/jump target is presented this cycle.
REQ-007 The block SHALL have port redirect_addr, input, AddrSize bits: the new fetch address; bits [1:0] are ignored and treated as 0.
REQ-008 The block SHALL have port imem_req_valid, output, 1 bit: an instruction-memory read request is presented.
REQ-009 The block SHALL have port imem_req_addr, output, AddrSize bits: the request address, always word-aligned.
REQ-010 The block SHALL have port imem_req_ready, input, 1 bit: memory accepts the request when imem_req_valid and imem_req_ready are both high.
REQ-011 The block SHALL have port imem_rsp_valid, input, 1 bit: a read response is present; responses arrive in order, at least 1 cycle after acceptance, and the block has no backpressure on them.
REQ-012 The block SHALL have port imem_rsp_data, input, DataSize bits: the response instruction word.
REQ-013 The block SHALL have port instr_valid, output, 1 bit: the queue head is valid for decode.
REQ-014 The block SHALL have port instr_data, output, DataSize bits: the queue-head instruction.
REQ-015 The block SHALL have port instr_pc, output, AddrSize bits: the address of the queue-head instruction.
REQ-016 The block SHALL have port instr_ready, input, 1 bit: decode consumes the head when instr_valid and instr_ready are both high.

Function
REQ-017 The block SHALL hold a request address fetch_pc, a response address rsp_pc, a FIFO of Depth entries of {pc,data}, an outstanding-request count, and a stale-response count.
REQ-018 The block SHALL implement a two-state FSM with states FETCH and DRAIN.
REQ-019 In FETCH, imem_req_valid SHALL equal (occupancy + outstanding < Depth) AND NOT redirect_valid, driven combinationally; imem_req_addr SHALL equal fetch_pc.
REQ-020 In DRAIN, imem_req_valid SHALL be 0.
REQ-021 On each accepted request, fetch_pc SHALL advance by 4, modulo 2^AddrSize (0xFFFFFFFC wraps to 0x00000000), and outstanding SHALL increment.
REQ-022 On each response that is not stale, the block SHALL enqueue {rsp_pc, imem_rsp_data}, advance rsp_pc by 4 with the same wrap rule, and decrement outstanding.
REQ-023 When the stale count is nonzero, a response SHALL be discarded and the stale count decremented.
REQ-024 The credit rule in REQ-019 SHALL guarantee that an enqueue never meets a full FIFO; the FIFO SHALL support a simultaneous enqueue and dequeue.
REQ-025 instr_valid SHALL be 1 exactly when the FIFO is non-empty, and instr_data/instr_pc SHALL show the head entry with zero-cycle visibility.
REQ-026 On redirect_valid, at the next edge the block SHALL: empty the FIFO; set fetch_pc and rsp_pc to {redirect_addr[AddrSize-1:2],2'b00}; set stale to the total requests accepted but not yet responded, counting any response in that same cycle as consumed; set outstanding to 0.
REQ-027 After a redirect, the next state SHALL be DRAIN if the new stale count is greater than 0, otherwise FETCH.
REQ-028 In DRAIN, the block SHALL return to FETCH on the edge at which the last stale response is discarded; the first post-redirect request SHALL be issued in the following cycle.
REQ-029 When redirect_valid and an instr handshake occur in the same cycle, the block SHALL treat the popped entry as consumed and still flush the FIFO.
REQ-030 When redirect_valid and imem_rsp_valid occur in the same cycle, the block SHALL discard the response.
REQ-031 A redirect during DRAIN SHALL reload the addresses and keep the remaining stale count unchanged.

Reset
REQ-032 While reset is high, imem_req_valid and instr_valid SHALL be 0.
REQ-033 At an edge with reset high, the block SHALL set fetch_pc=0, rsp_pc=0, state=FETCH, FIFO empty, outstanding=0, stale=0.
REQ-034 Reset SHALL take priority over redirect and all handshakes.
REQ-035 The instruction memory is reset by the same reset, so no response for a pre-reset request arrives after reset; the block SHALL NOT track such responses.

Verification
REQ-036 Reset release, imem_req_ready=1, memory with 1-cycle latency, instr_ready=1 -> requests to 0x0,0x4,0x8 on consecutive cycles; instr_pc 0x0,0x4,0x8 delivered in order with the matching data.
REQ-037 Depth=4, instr_ready=0 -> exactly 4 requests are accepted and imem_req_valid then stays 0; raising instr_ready for 1 cycle -> exactly one new request.
REQ-038 3 requests outstanding, redirect_addr=0x103 -> next state DRAIN with stale=3, 3 responses discarded, then first request at 0x100 and first instr_pc=0x100.
REQ-039 Redirect in the same cycle as a response and an instr handshake -> response discarded, FIFO empty next cycle, instr_valid=0.
REQ-040 Redirect to 0xFFFFFFF8 -> request addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000.
REQ-041 Reset asserted mid-DRAIN -> next cycle outputs are idle; after release, the first request address is 0x0.
